shift_left: RTL and testbench

- Registered playfield scroller for the Flappy Bird display pipeline.
- Takes a 16x16 one-bit-per-cell board (the "green" pipe layer) and, when enabled, outputs it on the next clock moved one column toward screen-left.
- The vacated right-hand column is zero-filled, or wrapped if configured.
- Downstream logic feeds `new_green` back as `green` each game tick to animate scrolling pipes.

---
 rtl/flappy_pkg.sv | 18 +
 rtl/shift_row.sv | 39 +++
 rtl/shift_left.sv | 61 ++++++
 tb/tb_shift_left.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg
//   Shared board geometry and types for the Flappy Bird display pipeline.
//
//   BOARD_ROWS / BOARD_COLS : default playfield size.
//   row_t                   : one row of cells. Bit 0 is the leftmost column
//                             on screen.
//   board_t                 : the whole playfield, indexed [row][col].
// ---------------------------------------------------------------------------
package flappy_pkg;

  localparam int BOARD_ROWS = 16;
  localparam int BOARD_COLS = 16;

  typedef logic [BOARD_COLS-1:0] row_t;
  typedef row_t [BOARD_ROWS-1:0] board_t;

endpackage : flappy_pkg

// File: rtl/shift_row.sv
// ---------------------------------------------------------------------------
// shift_row
//   Combinational shift of one board row by one column toward screen-left.
//   Screen-left is the lower column index, so the row value moves right by
//   one bit.
//
//   Parameters
//     COLS : row width in cells (must be at least 2).
//     WRAP : 0 = the vacated rightmost column is filled with 0.
//            1 = the leftmost column rotates into the rightmost column.
//
//   Ports
//     row_in  [COLS-1:0] : current row, bit c = column c.
//     row_out [COLS-1:0] : shifted row.
// ---------------------------------------------------------------------------
module shift_row
  import flappy_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter bit WRAP = 1'b0
) (
  input  logic [COLS-1:0] row_in,
  output logic [COLS-1:0] row_out
);

  logic fill_bit;

  generate
    if (WRAP) begin : g_wrap
      assign fill_bit = row_in[0];
    end else begin : g_zero
      assign fill_bit = 1'b0;
    end
  endgenerate

  // Column c takes column c+1; the top column takes the fill bit.
  assign row_out = {fill_bit, row_in[COLS-1:1]};

endmodule : shift_row

// File: rtl/shift_left.sv
// ---------------------------------------------------------------------------
// shift_left
//   Registered playfield scroller. When enable is high, the board presented
//   on green appears on new_green one clock later, moved one column toward
//   screen-left. When enable is low, new_green keeps its value. Rows are
//   shifted independently; there is no vertical movement.
//
//   Parameters
//     ROWS : number of board rows.
//     COLS : number of columns per row (column 0 is leftmost on screen).
//     WRAP : 0 = zero-fill the vacated column; 1 = rotate leftmost into it.
//
//   Ports
//     clk       : system clock, rising-edge active.
//     rst       : synchronous active-high reset; clears new_green and takes
//                 priority over enable.
//     enable    : shift strobe, sampled on each rising clk edge.
//     green     : current board, green[r][c] = cell (row r, column c).
//     new_green : registered shifted board.
// ---------------------------------------------------------------------------
module shift_left
  import flappy_pkg::*;
#(
  parameter int ROWS = BOARD_ROWS,
  parameter int COLS = BOARD_COLS,
  parameter bit WRAP = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [ROWS-1:0][COLS-1:0]  green,
  output logic [ROWS-1:0][COLS-1:0]  new_green
);

  logic [ROWS-1:0][COLS-1:0] shifted;

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      shift_row #(
        .COLS (COLS),
        .WRAP (WRAP)
      ) u_shift_row (
        .row_in  (green[r]),
        .row_out (shifted[r])
      );
    end
  endgenerate

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its inputs from before the edge, whatever the block order.
  // The whole board register is reset: it is what downstream feeds back,
  // so it must start from a known all-zero board.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_green <= '0;
    end else if (enable) begin
      new_green <= shifted;
    end
  end

endmodule : shift_left

// File: tb/tb_shift_left.sv
// ---------------------------------------------------------------------------
// tb_shift_left
//   Directed bench for shift_left. One instance uses zero fill (WRAP=0) and
//   one uses rotation (WRAP=1). They share clk, rst and enable, and each has
//   its own green input so that both can run in feedback mode.
// ---------------------------------------------------------------------------
module tb_shift_left;
  import flappy_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   enable;
  board_t green0, green1;
  board_t new_green0, new_green1;

  int n_vec  = 0;
  int n_fail = 0;

  shift_left #(.ROWS(BOARD_ROWS), .COLS(BOARD_COLS), .WRAP(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .green     (green0),
    .new_green (new_green0)
  );

  shift_left #(.ROWS(BOARD_ROWS), .COLS(BOARD_COLS), .WRAP(1'b1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .green     (green1),
    .new_green (new_green1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string  name;
    logic   rst;
    logic   enable;
    board_t green;
    board_t exp0;   // expected new_green for WRAP=0
    board_t exp1;   // expected new_green for WRAP=1
  } vec_t;

  vec_t vecs[8];

  // Board with rows 0..3 set individually and rows 4..15 all set to 'rest'.
  function automatic board_t make_board(input row_t r0, input row_t r1,
                                        input row_t r2, input row_t r3,
                                        input row_t rest);
    board_t b;
    for (int r = 0; r < BOARD_ROWS; r++) b[r] = rest;
    b[0] = r0;
    b[1] = r1;
    b[2] = r2;
    b[3] = r3;
    return b;
  endfunction

  function automatic vec_t mk_vec(input string name, input logic r,
                                  input logic en, input board_t g,
                                  input board_t e0, input board_t e1);
    vec_t v;
    v.name   = name;
    v.rst    = r;
    v.enable = en;
    v.green  = g;
    v.exp0   = e0;
    v.exp1   = e1;
    return v;
  endfunction

  // Popcount of every row, packed into one value (5 bits per row).
  function automatic logic [BOARD_ROWS*5-1:0] row_pops(input board_t b);
    logic [BOARD_ROWS*5-1:0] p;
    p = '0;
    for (int r = 0; r < BOARD_ROWS; r++) begin
      logic [4:0] cnt;
      cnt = '0;
      for (int c = 0; c < BOARD_COLS; c++) cnt = cnt + 5'(b[r][c]);
      p[r*5 +: 5] = cnt;
    end
    return p;
  endfunction

  task automatic check(input string name, input board_t act, input board_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name, input logic [BOARD_ROWS*5-1:0] act,
                           input logic [BOARD_ROWS*5-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: row popcounts got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle just past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  board_t pat, pat_s0, pat_s1, ones, zeros, lsb_only, msb_only, r7fff;
  board_t fb_start, fb_exp10;
  logic [BOARD_ROWS*5-1:0] pop_start;

  initial begin
    pat      = make_board(16'hAAAA, 16'hCCCC, 16'hF0F0, 16'h0F0F, 16'hFFFF);
    pat_s0   = make_board(16'h5555, 16'h6666, 16'h7878, 16'h0787, 16'h7FFF);
    pat_s1   = make_board(16'h5555, 16'h6666, 16'h7878, 16'h8787, 16'hFFFF);
    ones     = make_board(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    zeros    = make_board(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    lsb_only = make_board(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    msb_only = make_board(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    r7fff    = make_board(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    // Ten zero-fill shifts of pat: each row shifted right by 10 bits.
    fb_exp10 = make_board(16'h002A, 16'h0033, 16'h003C, 16'h0003, 16'h003F);

    vecs[0] = mk_vec("reset_all_ones", 1'b1, 1'b1, ones,     zeros,  zeros);
    vecs[1] = mk_vec("shift_pattern",  1'b0, 1'b1, pat,      pat_s0, pat_s1);
    vecs[2] = mk_vec("hold_ignores_g", 1'b0, 1'b0, ones,     pat_s0, pat_s1);
    vecs[3] = mk_vec("lsb_wraps",      1'b0, 1'b1, lsb_only, zeros,  msb_only);
    vecs[4] = mk_vec("all_zero",       1'b0, 1'b1, zeros,    zeros,  zeros);
    vecs[5] = mk_vec("all_ones",       1'b0, 1'b1, ones,     r7fff,  ones);
    vecs[6] = mk_vec("reset_no_en",    1'b1, 1'b0, pat,      zeros,  zeros);
    vecs[7] = mk_vec("shift_again",    1'b0, 1'b1, pat,      pat_s0, pat_s1);

    rst    = 1'b1;
    enable = 1'b0;
    green0 = '0;
    green1 = '0;

    // ---- table-driven single-edge vectors ----
    for (int i = 0; i < 8; i++) begin
      rst    = vecs[i].rst;
      enable = vecs[i].enable;
      green0 = vecs[i].green;
      green1 = vecs[i].green;
      step();
      check({vecs[i].name, "/wrap0"}, new_green0, vecs[i].exp0);
      check({vecs[i].name, "/wrap1"}, new_green1, vecs[i].exp1);
    end

    // ---- hold: five cycles of random green with enable low ----
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < BOARD_ROWS; r++) begin
        green0[r] = 16'($urandom_range(0, 65535));
        green1[r] = 16'($urandom_range(0, 65535));
      end
      step();
      check($sformatf("hold%0d/wrap0", k), new_green0, pat_s0);
      check($sformatf("hold%0d/wrap1", k), new_green1, pat_s1);
    end

    // ---- feedback: new_green drives green every cycle ----
    fb_start  = pat;
    pop_start = row_pops(fb_start);
    green0    = fb_start;
    green1    = fb_start;
    enable    = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 10) check("feedback10/wrap0", new_green0, fb_exp10);
      if (k == 16) begin
        check("feedback16/wrap0", new_green0, zeros);
        check("feedback16/wrap1", new_green1, fb_start);
      end
      if (k == 32) check("feedback32/wrap1", new_green1, fb_start);
      check_pop($sformatf("popcount%0d/wrap1", k), row_pops(new_green1), pop_start);
      green0 = new_green0;
      green1 = new_green1;
    end

    // ---- reset asserted mid feedback run ----
    green0 = pat;
    green1 = pat;
    step();
    check("midrun_pre/wrap0", new_green0, pat_s0);
    green0 = new_green0;
    green1 = new_green1;
    rst    = 1'b1;
    step();
    check("midrun_rst/wrap0", new_green0, zeros);
    check("midrun_rst/wrap1", new_green1, zeros);
    rst    = 1'b0;
    green0 = pat;
    green1 = pat;
    step();
    check("after_rst/wrap0", new_green0, pat_s0);
    check("after_rst/wrap1", new_green1, pat_s1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_shift_left
